// File: rtl/imm_issue_stage_if.sv
// Handshake and data bundle between decode, the immediate issue stage and execute.
// The stage itself connects through the slave modport; the decode/execute side uses master.
interface imm_issue_stage_if #(
  parameter int NUM_SLOTS = 2,
  parameter int INSTR_W   = 32
);
  logic                          flush;
  logic                          inValid;
  logic                          inReady;
  logic [NUM_SLOTS*INSTR_W-1:0]  instrIn;
  logic [2*NUM_SLOTS-1:0]        immSel;
  logic                          outValid;
  logic                          outReady;
  logic [NUM_SLOTS*INSTR_W-1:0]  instrOut;
  logic [32*NUM_SLOTS-1:0]       immOut;
  logic [1:0]                    occupancy;

  modport slave (
    input  flush, inValid, instrIn, immSel, outReady,
    output inReady, outValid, instrOut, immOut, occupancy
  );

  modport master (
    output flush, inValid, instrIn, immSel, outReady,
    input  inReady, outValid, instrOut, immOut, occupancy
  );
endinterface

// File: rtl/imm_issue_stage.sv
// Decode-to-execute stage: per-slot immediate extraction/extension, registered
// through a 2-entry skid buffer (output register + skid register) with flush.
//
// state   | meaning
// S_EMPTY | no bundle held, outValid=0
// S_ONE   | output register valid, skid empty
// S_TWO   | output and skid registers valid, inReady=0
module imm_issue_stage #(
  parameter int NUM_SLOTS = 2,
  parameter int INSTR_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  imm_issue_stage_if.slave   bus
);

  localparam int BW = NUM_SLOTS * INSTR_W;
  localparam int IW = 32 * NUM_SLOTS;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            in_ready_q;
  logic            out_valid;
  logic            acc;
  logic            hand;
  logic            out_load_in;
  logic            out_load_skid;
  logic            skid_load_in;
  logic [IW-1:0]   imm_in;
  logic [BW-1:0]   out_instr_q;
  logic [IW-1:0]   out_imm_q;
  logic [BW-1:0]   skid_instr_q;
  logic [IW-1:0]   skid_imm_q;

  // Only the low 11 bits of a slot instruction ever feed an immediate.
  function automatic logic [31:0] ext_imm(input logic [10:0] f, input logic [1:0] sel);
    logic [31:0] r;
    case (sel)
      2'b01:   r = {{24{f[7]}}, f[7:0]};
      2'b10:   r = {24'h0, f[7:0]};
      2'b11:   r = {{21{f[10]}}, f[10:0]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always_comb begin
    imm_in = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      imm_in[32*k +: 32] = ext_imm(bus.instrIn[k*INSTR_W +: 11], bus.immSel[2*k +: 2]);
    end
  end

  assign out_valid = (state != S_EMPTY);
  assign acc       = bus.inValid && in_ready_q;
  assign hand      = out_valid && bus.outReady;

  // State register; inReady is a flop so it never combinationally follows outReady.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != S_TWO);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: begin
        if (acc) state_nxt = S_ONE;
      end
      S_ONE: begin
        if (acc && !hand)      state_nxt = S_TWO;
        else if (!acc && hand) state_nxt = S_EMPTY;
      end
      S_TWO: begin
        if (hand && !acc) state_nxt = S_ONE;
      end
      default: state_nxt = S_EMPTY;
    endcase
    if (bus.flush) state_nxt = S_EMPTY;
  end

  // Datapath load strobes; a flush suppresses every load so nothing new becomes visible.
  always_comb begin
    out_load_in   = 1'b0;
    out_load_skid = 1'b0;
    skid_load_in  = 1'b0;
    case (state)
      S_EMPTY: begin
        out_load_in = acc;
      end
      S_ONE: begin
        out_load_in  = acc && hand;
        skid_load_in = acc && !hand;
      end
      S_TWO: begin
        out_load_skid = hand;
        skid_load_in  = acc && hand;
      end
      default: begin
        out_load_in = 1'b0;
      end
    endcase
    if (bus.flush) begin
      out_load_in   = 1'b0;
      out_load_skid = 1'b0;
      skid_load_in  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_instr_q  <= '0;
      out_imm_q    <= '0;
      skid_instr_q <= '0;
      skid_imm_q   <= '0;
    end else begin
      if (out_load_in) begin
        out_instr_q <= bus.instrIn;
        out_imm_q   <= imm_in;
      end else if (out_load_skid) begin
        out_instr_q <= skid_instr_q;
        out_imm_q   <= skid_imm_q;
      end
      if (skid_load_in) begin
        skid_instr_q <= bus.instrIn;
        skid_imm_q   <= imm_in;
      end
    end
  end

  assign bus.inReady   = in_ready_q;
  assign bus.outValid  = out_valid;
  assign bus.instrOut  = out_instr_q;
  assign bus.immOut    = out_imm_q;
  assign bus.occupancy = state;

endmodule

// File: doc/imm_issue_stage.md
Name: imm_issue_stage

Overview:
- Decode-to-execute pipeline stage for the VLIW datapath.
- Takes a decoded instruction bundle with a per-slot immediate-type select, and extracts and extends each slot's offset field to 32 bits.
- Registers the results into the execute stage through a 2-entry skid buffer with valid/ready handshake and flush.
- Its immediate outputs feed the ALU operand muxes and the address-generation units directly.

Parameters:
- NUM_SLOTS, 2, number of issue slots per VLIW bundle.
- INSTR_W, 32, width of one slot instruction.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush (branch redirect).
- inValid  input  1  upstream bundle valid.
- inReady  output  1  stage can accept a bundle this cycle.
- instrIn  input  NUM_SLOTS*INSTR_W  bundle; slot k at [k*INSTR_W +: INSTR_W].
- immSel  input  2*NUM_SLOTS  per-slot select; slot k at [2k +: 2].
- outValid  output  1  execute-side bundle valid.
- outReady  input  1  execute stage consumes the bundle this cycle.
- instrOut  output  NUM_SLOTS*INSTR_W  registered bundle, same packing as instrIn.
- immOut  output  32*NUM_SLOTS  extended immediates; slot k at [32k +: 32].
- occupancy  output  2  bundles held (0..2).

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted and after release:
  - outValid=0, inReady=1, occupancy=0.
  - instrOut=0, immOut=0.
  - Skid entry invalid and zeroed.
- Extension per slot, computed combinationally on instrIn before the register (i = slot instruction):
  - immSel 00: 32'h0.
  - immSel 01: sign-extend i[7:0]. Bits [31:8] = i[7].
  - immSel 10: zero-extend i[7:0]. Bits [31:8] = 0, bits [7:0] = i[7:0] unchanged.
  - immSel 11: sign-extend i[10:0]. Bits [31:11] = i[10].
  - Each slot is independent. A slot's select never affects another slot.
- Storage: one output register plus one skid register.
  - Each holds {instr, imm} for all slots plus a valid bit.
- inReady is registered and equals !skidValid. It is never derived combinationally from outReady.
- Accept: inValid && inReady at the clock edge.
- Output handoff: outValid && outReady.
- Cycle rules (no flush):
  - Output empty, or handing off, and skid empty: accepted bundle loads the output register. outValid=1 next cycle (latency 1).
  - Output handing off and skid valid: skid moves to the output register, skid clears. If an accept happens the same cycle, the new bundle goes to the skid. This cannot occur with the registered inReady, but RTL must not lose data.
  - Output valid, not handing off, accept: bundle goes to the skid. inReady=0 next cycle.
  - Output valid, not handing off, no accept: all state holds.
  - Output handing off, nothing accepted, skid empty: outValid=0 next cycle.
- Ordering is strictly FIFO. A bundle never bypasses an older one.
- instrOut/immOut are stable while outValid=1 && outReady=0.
- occupancy = outValid + skidValid, updated each cycle.
- flush (synchronous) overrides all other events in the same cycle:
  - Next cycle: outValid=0, skid invalid, inReady=1, occupancy=0.
  - An input accepted in the flush cycle is discarded.
  - Data registers may hold stale values, but outValid=0 marks them invalid.
- Reset asserted mid-stall: state clears immediately, without waiting for clk. Pending bundles are lost.
- outReady with outValid=0 has no effect.
- inValid with inReady=0 is not consumed. Upstream must hold the bundle.

Test Plan:
- Reset, then idle -> outValid=0, inReady=1, occupancy=0, immOut=0. Assert reset asynchronously between edges -> outputs clear before the next edge.
- Extension with outReady=1:
  - Slot0 instr[7:0]=8'h80, sel 01 -> 32'hFFFFFF80.
  - Slot1 instr[7:0]=8'hFF, sel 10 -> 32'h000000FF.
  - Next bundle: slot0 instr[10:0]=11'h400, sel 11 -> 32'hFFFFFC00. Slot1 instr[10:0]=11'h3FF, sel 11 -> 32'h000003FF.
  - All results appear 1 cycle after accept.
- Sel 00 with instr=32'hFFFFFFFF -> immOut slot=0. Bits above [10] set with sel 11 and i[10]=0 -> upper bits 0.
- Backpressure: outReady=0, three back-to-back bundles A,B,C:
  - A goes to output, B to skid, inReady=0, C held upstream, occupancy=2.
  - Release outReady -> A, B, C emerge in order, no gaps after the first release cycle.
- Flush in the same cycle as inValid=1, with occupancy=2 -> next cycle occupancy=0, outValid=0, inReady=1. The flushed-cycle input never appears.
- Random valid/ready toggling for 1000 bundles against a scoreboard model -> zero loss, no duplication, order preserved, and immOut matches the reference extension for every slot.
